// File: rtl/arb3_rr_moore_ctrl_if.sv
// Request/grant bundle between the requesters and the 3-way round-robin arbiter.
// The slave modport is the arbiter's view; the master modport is the requester side.
interface arb3_rr_moore_ctrl_if #(
  parameter int CW = 4
);
  logic [2:0]    x;
  logic [2:0]    gnt;
  logic [1:0]    gnt_id;
  logic          busy;
  logic [CW-1:0] hold_cnt;
  logic          timeout;

  modport master (
    output x,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  hold_cnt,
    input  timeout
  );

  modport slave (
    input  x,
    output gnt,
    output gnt_id,
    output busy,
    output hold_cnt,
    output timeout
  );
endinterface

// File: rtl/arb3_rr_moore_ctrl.sv
// Registered 3-requester round-robin arbiter with Moore grant outputs,
// a bounded grant-hold counter and a one-cycle forced-release pulse.
module arb3_rr_moore_ctrl #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  arb3_rr_moore_ctrl_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] G0   = 2'b01;
  localparam logic [1:0] G1   = 2'b10;
  localparam logic [1:0] G2   = 2'b11;

  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  logic [1:0]    state_reg,    state_next;
  logic [1:0]    last_reg,     last_next;
  logic [CW-1:0] hold_cnt_reg, hold_cnt_next;
  logic          timeout_reg,  timeout_next;

  logic [1:0]    cur_id;
  logic          at_limit;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Returns the grant state for the first active request after pointer p,
  // scanning p+1, p+2 and finally p itself; IDLE if nothing is requesting.
  function automatic logic [1:0] pick(input logic [2:0] req, input logic [1:0] p);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = inc3(p);
    c2 = inc3(c1);
    if (req[c1])
      return c1 + 2'd1;
    else if (req[c2])
      return c2 + 2'd1;
    else if (req[p])
      return p + 2'd1;
    else
      return IDLE;
  endfunction

  assign cur_id   = state_reg - 2'd1;
  assign at_limit = (hold_cnt_reg == HOLD_LAST);

  always_comb begin
    state_next    = state_reg;
    last_next     = last_reg;
    hold_cnt_next = hold_cnt_reg;
    timeout_next  = 1'b0;
    if (state_reg == IDLE) begin
      state_next    = pick(bus.x, last_reg);
      hold_cnt_next = '0;
    end else if (bus.x[cur_id] && !at_limit) begin
      hold_cnt_next = hold_cnt_reg + CW'(1);
    end else begin
      // Release: a still-high own request here can only mean the limit forced it.
      last_next     = cur_id;
      state_next    = pick(bus.x, cur_id);
      hold_cnt_next = '0;
      timeout_next  = bus.x[cur_id];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      last_reg     <= 2'd2;
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      last_reg     <= last_next;
      hold_cnt_reg <= hold_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_gnt
      assign bus.gnt[gi] = (state_reg == 2'(gi + 1));
    end
  endgenerate

  assign bus.busy     = (state_reg != IDLE);
  assign bus.gnt_id   = bus.busy ? cur_id : 2'd0;
  assign bus.hold_cnt = hold_cnt_reg;
  assign bus.timeout  = timeout_reg;

endmodule

// File: tb/tb_arb3_rr_moore_ctrl.sv
// Directed bench for arb3_rr_moore_ctrl: three instances with MAX_HOLD 8, 4 and 1
// share clock and reset; each step is checked with an immediate assertion.
module tb_arb3_rr_moore_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  arb3_rr_moore_ctrl_if #(.CW(4)) if8 ();
  arb3_rr_moore_ctrl_if #(.CW(4)) if4 ();
  arb3_rr_moore_ctrl_if #(.CW(1)) if1 ();

  arb3_rr_moore_ctrl #(.MAX_HOLD(8), .CW(4)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  arb3_rr_moore_ctrl #(.MAX_HOLD(4), .CW(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  arb3_rr_moore_ctrl #(.MAX_HOLD(1), .CW(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    if8.x  = 3'b111;
    if4.x  = 3'b000;
    if1.x  = 3'b000;

    // Reset state with all requests high
    tick();
    tick();
    chk("rst_gnt",     int'(if8.gnt), 0);
    chk("rst_gnt_id",  int'(if8.gnt_id), 0);
    chk("rst_busy",    int'(if8.busy), 0);
    chk("rst_hold",    int'(if8.hold_cnt), 0);
    chk("rst_timeout", int'(if8.timeout), 0);
    $display("step reset: gnt=%b busy=%b", if8.gnt, if8.busy);

    // First edge after release: requester 0 has priority
    rst_n = 1'b1;
    tick();
    chk("first_gnt",    int'(if8.gnt), 'b001);
    chk("first_gnt_id", int'(if8.gnt_id), 0);
    chk("first_busy",   int'(if8.busy), 1);
    chk("first_hold",   int'(if8.hold_cnt), 0);
    $display("step first grant: gnt=%b id=%0d", if8.gnt, if8.gnt_id);

    // Round-robin rotation: after 3 grant cycles drop the owner's bit for one cycle
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rot_hold1", int'(if8.hold_cnt), 1);
      tick();
      chk("rot_hold2", int'(if8.hold_cnt), 2);
      if8.x = 3'b111 & ~(3'b001 << k);
      tick();
      chk("rot_gnt",     int'(if8.gnt), int'(3'b001 << ((k + 1) % 3)));
      chk("rot_busy",    int'(if8.busy), 1);
      chk("rot_hold0",   int'(if8.hold_cnt), 0);
      chk("rot_timeout", int'(if8.timeout), 0);
      $display("step rotate %0d: gnt=%b timeout=%b", k, if8.gnt, if8.timeout);
      if8.x = 3'b111;
    end
    if8.x = 3'b000;
    tick();
    chk("idle_gnt",  int'(if8.gnt), 0);
    chk("idle_busy", int'(if8.busy), 0);
    chk("idle_hold", int'(if8.hold_cnt), 0);

    // Forced release with a contender, MAX_HOLD=4
    if4.x = 3'b011;
    tick();
    chk("frc_gnt0", int'(if4.gnt), 'b001);
    chk("frc_hold", int'(if4.hold_cnt), 0);
    for (int c = 1; c < 4; c++) begin
      tick();
      chk("frc_gnt0", int'(if4.gnt), 'b001);
      chk("frc_hold", int'(if4.hold_cnt), c);
      chk("frc_to0",  int'(if4.timeout), 0);
    end
    tick();
    chk("frc_gnt1",    int'(if4.gnt), 'b010);
    chk("frc_timeout", int'(if4.timeout), 1);
    chk("frc_hold0",   int'(if4.hold_cnt), 0);
    $display("step forced handover: gnt=%b timeout=%b", if4.gnt, if4.timeout);
    tick();
    chk("frc_pulse_end", int'(if4.timeout), 0);
    chk("frc_hold1",     int'(if4.hold_cnt), 1);

    // Sole requester: voluntary handover to G2, then periodic re-grant
    if4.x = 3'b100;
    tick();
    chk("sole_gnt",  int'(if4.gnt), 'b100);
    chk("sole_hold", int'(if4.hold_cnt), 0);
    chk("sole_to",   int'(if4.timeout), 0);
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("sole_gnt",  int'(if4.gnt), 'b100);
      chk("sole_hold", int'(if4.hold_cnt), (j + 1) % 4);
      chk("sole_to",   int'(if4.timeout), ((j + 1) % 4 == 0) ? 1 : 0);
      $display("step sole %0d: gnt=%b hold=%0d timeout=%b", j, if4.gnt, if4.hold_cnt, if4.timeout);
    end

    // Simultaneous drop at the limit is a voluntary release
    if4.x = 3'b001;
    tick();
    chk("sim_gnt0", int'(if4.gnt), 'b001);
    tick();
    tick();
    tick();
    chk("sim_hold3", int'(if4.hold_cnt), 3);
    if4.x = 3'b010;
    tick();
    chk("sim_gnt1",    int'(if4.gnt), 'b010);
    chk("sim_timeout", int'(if4.timeout), 0);
    chk("sim_hold0",   int'(if4.hold_cnt), 0);
    $display("step simultaneous drop: gnt=%b timeout=%b", if4.gnt, if4.timeout);

    // Asynchronous reset in the middle of a grant
    tick();
    tick();
    chk("ar_hold2", int'(if4.hold_cnt), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gnt",  int'(if4.gnt), 0);
    chk("ar_busy", int'(if4.busy), 0);
    chk("ar_hold", int'(if4.hold_cnt), 0);
    $display("step async reset: gnt=%b busy=%b", if4.gnt, if4.busy);
    if4.x = 3'b110;
    rst_n = 1'b1;
    tick();
    chk("ar_regnt",   int'(if4.gnt), 'b010);
    chk("ar_gnt_id",  int'(if4.gnt_id), 1);
    chk("ar_hold0",   int'(if4.hold_cnt), 0);

    // MAX_HOLD=1: rotate every cycle, pulse only on forced release
    if1.x = 3'b111;
    tick();
    chk("mh1_gnt0", int'(if1.gnt), 'b001);
    chk("mh1_to0",  int'(if1.timeout), 0);
    tick();
    chk("mh1_gnt1", int'(if1.gnt), 'b010);
    chk("mh1_to1",  int'(if1.timeout), 1);
    tick();
    chk("mh1_gnt2", int'(if1.gnt), 'b100);
    tick();
    chk("mh1_gnt0b", int'(if1.gnt), 'b001);
    chk("mh1_hold",  int'(if1.hold_cnt), 0);
    if1.x = 3'b010;
    tick();
    chk("mh1_vol_gnt", int'(if1.gnt), 'b010);
    chk("mh1_vol_to",  int'(if1.timeout), 0);
    tick();
    chk("mh1_regnt",    int'(if1.gnt), 'b010);
    chk("mh1_regnt_to", int'(if1.timeout), 1);
    $display("step max_hold=1: gnt=%b timeout=%b", if1.gnt, if1.timeout);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arb3_rr_moore_ctrl.md
Name: arb3_rr_moore_ctrl

Overview:
- Registered 3-requester round-robin arbiter controller with Moore outputs; sequences one shared resource between requesters X0, X1, X2.
- Extends the team's combinational 2-bit-state arbiter next-state logic to a fully clocked block.
- Adds a rotating priority pointer, a grant-hold limit with forced release, and status outputs for the datapath mux and for debug.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one grant is held; legal range 1..2**CW.
- CW, 4, width of the hold counter; must represent MAX_HOLD-1.

Ports:
- CLK  input  1  single system clock, rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- X  input  3  request vector; X[i] high = requester i wants the resource; level-held.
- GNT  output  3  one-hot grant; all-zero when idle.
- GNT_ID  output  2  encoded granted requester, 0..2; 2'b00 when idle, so qualify with BUSY.
- BUSY  output  1  high while any grant is active.
- HOLD_CNT  output  CW  cycles elapsed in the current grant, 0-based.
- TIMEOUT  output  1  one-cycle pulse marking a forced release.

Behaviour:
- State Q[1:0]: IDLE=00, G0=01, G1=10, G2=11.
- GNT, GNT_ID and BUSY decode from Q only (Moore). No combinational path from X to any output.
- Reset (RST_N low, async): Q=IDLE, GNT=000, GNT_ID=00, BUSY=0, HOLD_CNT=0, TIMEOUT=0, LAST=2.
  - LAST is the internal pointer to the last granted requester; reset value 2 gives requester 0 first priority.
  - Reset asserted mid-grant drops GNT immediately, without waiting for an edge.
  - After reset release, the first edge samples X normally.
- Priority order from pointer p: p+1, p+2, p (mod 3).
- IDLE:
  - If X==000, stay in IDLE.
  - Otherwise go to Gj, where j is the first requester with X[j]=1 in priority order from LAST.
  - Latency: X sampled at edge k gives GNT at edge k, visible in the cycle after edge k (1 cycle).
- Gi, stay condition: X[i]=1 and HOLD_CNT < MAX_HOLD-1. HOLD_CNT increments by 1 per cycle while staying.
- Gi, release condition: X[i]=0 (voluntary) or HOLD_CNT == MAX_HOLD-1 (forced). On release:
  - LAST<=i.
  - Next state is the first requester with X=1 in priority order from i, scanning i+1 and i+2 first.
  - If only X[i] is high (forced case), re-grant Gi.
  - If no requests, go to IDLE.
  - Grant-to-grant handover has no idle gap: GNT changes one-hot to one-hot in a single edge.
- HOLD_CNT:
  - Loads 0 on every entry to a grant state, including a re-grant of the same i.
  - Holds 0 in IDLE.
  - Never exceeds MAX_HOLD-1.
- TIMEOUT:
  - Registered; high for exactly the one cycle following a forced release.
  - If X[i] drops on the same edge that the limit is reached, the release is voluntary and TIMEOUT stays 0.
- MAX_HOLD=1: every grant lasts exactly 1 cycle. With continuous requests the block rotates every cycle; TIMEOUT pulses only when X[i] is still high at release.
- X is assumed synchronous to CLK; no internal synchronizers.

Test Plan:
- Reset/priority: hold RST_N=0, X=111, then release → GNT=000 during reset; one cycle after the first edge, GNT=001, GNT_ID=0, BUSY=1, HOLD_CNT=0.
- Round-robin rotation: MAX_HOLD=8, X=111; drop each granted requester's bit for one cycle after 3 grant cycles → grant sequence G0→G1→G2→G0 with no idle cycle between grants; TIMEOUT stays 0.
- Forced release with contender: MAX_HOLD=4, X=011 held constant → G0 for exactly 4 cycles (HOLD_CNT 0,1,2,3), then G1, TIMEOUT=1 for one cycle, HOLD_CNT=0.
- Forced release, sole requester: MAX_HOLD=4, X=100 held → G2 for 4 cycles, then re-grant G2 with HOLD_CNT back to 0, one TIMEOUT pulse per 4 cycles, GNT never 000.
- Simultaneous drop at limit: MAX_HOLD=4, X=001; clear X[0] on the edge where HOLD_CNT=3 while X[1] rises → next state G1, TIMEOUT=0.
- Async reset mid-grant: in G1 with HOLD_CNT=2, pulse RST_N low between edges → GNT=000 and BUSY=0 immediately; after release with X=110, grant goes to G1, since LAST=2 makes priority 0,1,2.
